// File: rtl/state_sequencer.sv
// LC-3b microsequencer: walks the fetch/decode/execute microstates, stalls on memory,
// counts retired instructions and halts on illegal opcodes or a memory watchdog timeout.
module state_sequencer #(
  parameter int WD_MAX = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        run,
  input  logic [15:0] IR,
  input  logic        N,
  input  logic        Z,
  input  logic        P,
  input  logic        mem_ready,
  output logic [4:0]  StateID,
  output logic        mem_req,
  output logic        instr_done,
  output logic [15:0] retired,
  output logic        err,
  output logic        halted
);

  typedef enum logic [4:0] {
    S0  = 5'd0,  S1  = 5'd1,  S2  = 5'd2,  S3  = 5'd3,  S4  = 5'd4,
    S5  = 5'd5,  S6  = 5'd6,  S7  = 5'd7,  S8  = 5'd8,  S9  = 5'd9,
    S10 = 5'd10, S11 = 5'd11, S13 = 5'd13, S15 = 5'd15, S18 = 5'd18,
    S19 = 5'd19, S21 = 5'd21, S22 = 5'd22, S23 = 5'd23, S24 = 5'd24,
    S25 = 5'd25, S26 = 5'd26, S28 = 5'd28, S29 = 5'd29, S30 = 5'd30
  } state_t;

  localparam logic [7:0] WD_LIM = 8'(WD_MAX);

  state_t     state;
  state_t     next;
  logic [7:0] wd;
  logic       ben;
  logic       stall;
  logic       wd_fire;
  logic       retire;
  logic       unused_ir;

  assign unused_ir = &{1'b0, IR[8:0]};
  assign StateID   = state;
  assign mem_req   = state inside {S1, S2, S15, S18, S24, S25, S28};
  assign ben       = (IR[11] & N) | (IR[10] & Z) | (IR[9] & P);
  assign stall     = mem_req & ~mem_ready;
  assign wd_fire   = stall & (wd == WD_LIM);
  // Fetch from IDLE is not a retirement; holding in state 1 is not a new entry.
  assign retire    = (next == S1) && (state != S0) && (state != S1);

  always_comb begin
    next = S22;
    case (state)
      S0:  next = run ? S1 : S0;
      S1:  next = S2;
      S2:  next = S3;
      S3: begin
        case (IR[15:12])
          4'b0001, 4'b0101, 4'b1001, 4'b1101: next = S4;
          4'b0000: next = ben ? S6 : S1;
          4'b1100: next = S7;
          4'b0100: next = S8;
          4'b1110: next = S10;
          4'b0010: next = S13;
          4'b0110: next = S23;
          4'b0011: next = S26;
          4'b0111: next = S29;
          default: next = S22;
        endcase
      end
      S4:  next = S5;
      S5:  next = S1;
      S6:  next = S1;
      S7:  next = S1;
      S8:  next = S9;
      S9:  next = S1;
      S10: next = S11;
      S11: next = S1;
      S13: next = S15;
      S15: next = S21;
      S21: next = S1;
      S23: next = S24;
      S24: next = S18;
      S18: next = S19;
      S19: next = S1;
      S26: next = S28;
      S28: next = S1;
      S29: next = S25;
      S25: next = S30;
      S30: next = S1;
      S22: next = S22;
      default: next = S22;
    endcase
    // A memory stall overrides the advance; an expired watchdog forces HALT.
    if (stall) next = wd_fire ? S22 : state;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S0;
      instr_done <= 1'b0;
      retired    <= 16'h0000;
      err        <= 1'b0;
      halted     <= 1'b0;
      wd         <= 8'h00;
    end else begin
      state      <= next;
      instr_done <= retire;
      halted     <= (next == S22);
      if (retire) retired <= retired + 16'h0001;
      if (wd_fire) err <= 1'b1;
      // Any state change restarts the count, so it is zero on entry to each wait state.
      if (next != state) wd <= 8'h00;
      else if (stall)    wd <= wd + 8'h01;
    end
  end

endmodule

// File: tb/tb_state_sequencer.sv
// Directed-vector bench for state_sequencer: each task drives one scenario and
// compares outputs 1 time unit after the rising edge against hand-computed values.
module tb_state_sequencer;

  localparam int WD = 255;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        run = 1'b0;
  logic [15:0] IR = 16'h0000;
  logic        N = 1'b0, Z = 1'b0, P = 1'b0;
  logic        mem_ready = 1'b0;
  logic [4:0]  StateID;
  logic        mem_req, instr_done, err, halted;
  logic [15:0] retired;

  int vectors = 0;
  int miscompares = 0;

  state_sequencer dut (
    .clk(clk), .reset(reset), .run(run), .IR(IR), .N(N), .Z(Z), .P(P),
    .mem_ready(mem_ready), .StateID(StateID), .mem_req(mem_req),
    .instr_done(instr_done), .retired(retired), .err(err), .halted(halted)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL timeout simulation did not finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1; run = 1'b0; mem_ready = 1'b0; IR = 16'h0000;
    N = 1'b0; Z = 1'b0; P = 1'b0;
    tick();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; run = 1'b1; mem_ready = 1'b1; IR = 16'hF000;
    tick();
    vectors++; if (StateID !== 5'd0) begin miscompares++; $display("FAIL reset_state got %0d want 0", StateID); end
    vectors++; if (mem_req !== 1'b0) begin miscompares++; $display("FAIL reset_mem_req got %b want 0", mem_req); end
    vectors++; if (instr_done !== 1'b0) begin miscompares++; $display("FAIL reset_instr_done got %b want 0", instr_done); end
    vectors++; if (retired !== 16'h0000) begin miscompares++; $display("FAIL reset_retired got %h want 0000", retired); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL reset_err got %b want 0", err); end
    vectors++; if (halted !== 1'b0) begin miscompares++; $display("FAIL reset_halted got %b want 0", halted); end
    reset = 1'b0; run = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      vectors++; if (StateID !== 5'd0) begin miscompares++; $display("FAIL idle_hold[%0d] got %0d want 0", i, StateID); end
    end
  endtask

  task automatic test_add();
    logic [4:0] seq  [6] = '{5'd1, 5'd2, 5'd3, 5'd4, 5'd5, 5'd1};
    logic       req  [6] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    logic       done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    run = 1'b1; IR = 16'h1000; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (StateID !== seq[i]) begin miscompares++; $display("FAIL add_state[%0d] got %0d want %0d", i, StateID, seq[i]); end
      vectors++; if (mem_req !== req[i]) begin miscompares++; $display("FAIL add_mem_req[%0d] got %b want %b", i, mem_req, req[i]); end
      vectors++; if (instr_done !== done[i]) begin miscompares++; $display("FAIL add_done[%0d] got %b want %b", i, instr_done, done[i]); end
    end
    vectors++; if (retired !== 16'd1) begin miscompares++; $display("FAIL add_retired got %0d want 1", retired); end
  endtask

  task automatic test_branch();
    logic [4:0] seq  [8] = '{5'd1, 5'd2, 5'd3, 5'd1, 5'd2, 5'd3, 5'd6, 5'd1};
    logic       done [8] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
    do_reset();
    run = 1'b1; IR = 16'h0800; mem_ready = 1'b1; N = 1'b0; Z = 1'b1; P = 1'b1;
    for (int i = 0; i < 8; i++) begin
      if (i == 4) N = 1'b1;
      tick();
      vectors++; if (StateID !== seq[i]) begin miscompares++; $display("FAIL br_state[%0d] got %0d want %0d", i, StateID, seq[i]); end
      vectors++; if (instr_done !== done[i]) begin miscompares++; $display("FAIL br_done[%0d] got %b want %b", i, instr_done, done[i]); end
    end
    vectors++; if (retired !== 16'd2) begin miscompares++; $display("FAIL br_retired got %0d want 2", retired); end
  endtask

  task automatic test_wait_hold();
    logic [4:0] seq [5] = '{5'd1, 5'd2, 5'd3, 5'd23, 5'd24};
    do_reset();
    run = 1'b1; IR = 16'h6000; mem_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      vectors++; if (StateID !== seq[i]) begin miscompares++; $display("FAIL ldw_state[%0d] got %0d want %0d", i, StateID, seq[i]); end
    end
    mem_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      vectors++; if (StateID !== 5'd24) begin miscompares++; $display("FAIL ldw_hold[%0d] got %0d want 24", i, StateID); end
      vectors++; if (mem_req !== 1'b1) begin miscompares++; $display("FAIL ldw_hold_req[%0d] got %b want 1", i, mem_req); end
    end
    mem_ready = 1'b1;
    tick();
    vectors++; if (StateID !== 5'd18) begin miscompares++; $display("FAIL ldw_release got %0d want 18", StateID); end
    vectors++; if (err !== 1'b0) begin miscompares++; $display("FAIL ldw_err got %b want 0", err); end
    tick();
    vectors++; if (StateID !== 5'd19) begin miscompares++; $display("FAIL ldw_wb got %0d want 19", StateID); end
    tick();
    vectors++; if (StateID !== 5'd1 || instr_done !== 1'b1) begin miscompares++; $display("FAIL ldw_retire got %0d/%b want 1/1", StateID, instr_done); end
  endtask

  task automatic test_watchdog();
    do_reset();
    run = 1'b1; mem_ready = 1'b1;
    tick(); tick();
    vectors++; if (StateID !== 5'd2) begin miscompares++; $display("FAIL wd_enter got %0d want 2", StateID); end
    mem_ready = 1'b0;
    for (int i = 0; i < WD; i++) tick();
    vectors++; if (StateID !== 5'd2 || err !== 1'b0) begin miscompares++; $display("FAIL wd_at_limit got %0d/%b want 2/0", StateID, err); end
    tick();
    vectors++; if (StateID !== 5'd22) begin miscompares++; $display("FAIL wd_fire_state got %0d want 22", StateID); end
    vectors++; if (err !== 1'b1) begin miscompares++; $display("FAIL wd_fire_err got %b want 1", err); end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL wd_fire_halted got %b want 1", halted); end
    run = 1'b1; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (StateID !== 5'd22 || err !== 1'b1 || halted !== 1'b1 || mem_req !== 1'b0) begin
        miscompares++; $display("FAIL halt_hold[%0d] got %0d/%b/%b/%b want 22/1/1/0", i, StateID, err, halted, mem_req); end
    end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (StateID !== 5'd0 || err !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL halt_reset got %0d/%b/%b want 0/0/0", StateID, err, halted); end
    // Ready arrives exactly on the limit cycle.
    run = 1'b1; mem_ready = 1'b1; IR = 16'h1000;
    tick(); tick();
    mem_ready = 1'b0;
    for (int i = 0; i < WD; i++) tick();
    mem_ready = 1'b1;
    tick();
    vectors++; if (StateID !== 5'd3) begin miscompares++; $display("FAIL wd_ready_win got %0d want 3", StateID); end
    vectors++; if (err !== 1'b0 || halted !== 1'b0) begin miscompares++; $display("FAIL wd_ready_err got %b/%b want 0/0", err, halted); end
  endtask

  task automatic test_illegal_and_reset();
    logic [4:0] seq [4] = '{5'd1, 5'd2, 5'd3, 5'd22};
    do_reset();
    run = 1'b1; IR = 16'hF000; mem_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      tick();
      vectors++; if (StateID !== seq[i]) begin miscompares++; $display("FAIL ill_state[%0d] got %0d want %0d", i, StateID, seq[i]); end
    end
    vectors++; if (halted !== 1'b1) begin miscompares++; $display("FAIL ill_halted got %b want 1", halted); end
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    vectors++; if (StateID !== 5'd0 || halted !== 1'b0 || mem_req !== 1'b0 || instr_done !== 1'b0 || retired !== 16'h0 || err !== 1'b0) begin
      miscompares++; $display("FAIL ill_reset got %0d/%b/%b/%b/%h/%b want 0/0/0/0/0000/0", StateID, halted, mem_req, instr_done, retired, err); end
    // Reset while stalled in a wait state.
    run = 1'b1; mem_ready = 1'b0;
    tick(); tick();
    reset = 1'b1;
    tick();
    reset = 1'b0; run = 1'b0;
    vectors++; if (StateID !== 5'd0 || mem_req !== 1'b0) begin miscompares++; $display("FAIL wait_reset got %0d/%b want 0/0", StateID, mem_req); end
    // Reset on the edge that would retire a JMP.
    run = 1'b1; IR = 16'hC000; mem_ready = 1'b1;
    tick(); tick(); tick(); tick();
    vectors++; if (StateID !== 5'd7) begin miscompares++; $display("FAIL jmp_reach got %0d want 7", StateID); end
    reset = 1'b1;
    tick();
    reset = 1'b0;
    vectors++; if (StateID !== 5'd0 || instr_done !== 1'b0 || retired !== 16'h0) begin
      miscompares++; $display("FAIL retire_reset got %0d/%b/%h want 0/0/0000", StateID, instr_done, retired); end
  endtask

  task automatic test_ir_run_ignored();
    do_reset();
    run = 1'b1; IR = 16'hF000; mem_ready = 1'b1;
    tick();
    run = 1'b0;
    tick();
    vectors++; if (StateID !== 5'd2) begin miscompares++; $display("FAIL run_ignored got %0d want 2", StateID); end
    IR = 16'hC000;
    tick();
    vectors++; if (StateID !== 5'd3) begin miscompares++; $display("FAIL ir_fetch got %0d want 3", StateID); end
    IR = 16'hC000;
    tick();
    vectors++; if (StateID !== 5'd7) begin miscompares++; $display("FAIL ir_decode got %0d want 7", StateID); end
    IR = 16'hF000;
    tick();
    vectors++; if (StateID !== 5'd1 || instr_done !== 1'b1) begin miscompares++; $display("FAIL ir_late got %0d/%b want 1/1", StateID, instr_done); end
  endtask

  task automatic test_back_to_back_wrap();
    logic [4:0] seq  [6] = '{5'd1, 5'd2, 5'd3, 5'd7, 5'd1, 5'd2};
    logic       done [6] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    do_reset();
    force dut.retired = 16'hFFFF;
    tick();
    release dut.retired;
    run = 1'b1; IR = 16'hC000; mem_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick();
      vectors++; if (StateID !== seq[i]) begin miscompares++; $display("FAIL wrap_state[%0d] got %0d want %0d", i, StateID, seq[i]); end
      vectors++; if (instr_done !== done[i]) begin miscompares++; $display("FAIL wrap_done[%0d] got %b want %b", i, instr_done, done[i]); end
      if (i == 3) begin
        vectors++; if (retired !== 16'hFFFF) begin miscompares++; $display("FAIL wrap_pre got %h want ffff", retired); end
      end
    end
    vectors++; if (retired !== 16'h0000) begin miscompares++; $display("FAIL wrap_retired got %h want 0000", retired); end
  endtask

  initial begin
    test_reset();
    test_add();
    test_branch();
    test_wait_hold();
    test_watchdog();
    test_illegal_and_reset();
    test_ir_run_ignored();
    test_back_to_back_wrap();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/state_sequencer.md
STATE_SEQUENCER -- requirements
Module: state_sequencer

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: port clk is the clock, and reset is sampled on the rising edge of clk.
REQ-002 Ports SHALL be:
  clk  in  1  clock
  reset  in  1  synchronous active-high reset
  run  in  1  leave IDLE and start fetching
  IR  in  16  current instruction register
  N, Z, P  in  1 each  condition codes
  mem_ready  in  1  memory access complete this cycle
  StateID  out  5  current microstate, consumed by the LC-3b controller
  mem_req  out  1  memory access pending
  instr_done  out  1  one-cycle retire pulse
  retired  out  16  retired-instruction count
  err  out  1  memory watchdog fired (sticky)
  halted  out  1  sequencer is in HALT (state 22)
REQ-003 The watchdog limit SHALL be a parameter WD_MAX with default 255.

Function
REQ-004 StateID SHALL be a register, updated only on the rising edge of clk.
REQ-005 State 0 (IDLE): go to state 1 when run=1; otherwise stay in state 0.
REQ-006 The memory-wait states SHALL be 1, 2, 15, 18, 24, 25 and 28.
REQ-007 In a wait state the sequencer SHALL advance on a cycle with mem_ready=1 and hold on a cycle with mem_ready=0.
REQ-008 mem_req SHALL be 1 exactly when StateID is a wait state, decoded from the StateID register only.
REQ-009 Fetch path: 1 -> 2 -> 3.
REQ-010 Decode (state 3) SHALL branch on IR[15:12] as follows:
  0001, 0101, 1001, 1101: 4 -> 5 -> 1
  0000: 6 -> 1 if BEN=1; direct to 1 if BEN=0
  1100: 7 -> 1
  0100: 8 -> 9 -> 1
  1110: 10 -> 11 -> 1
  0010: 13 -> 15 -> 21 -> 1
  0110: 23 -> 24 -> 18 -> 19 -> 1
  0011: 26 -> 28 -> 1
  0111: 29 -> 25 -> 30 -> 1
  1000, 1010, 1011, 1111: 22
REQ-011 BEN SHALL be (IR[11]&N)|(IR[10]&Z)|(IR[9]&P), evaluated on the state-3 cycle.
REQ-012 IR SHALL be used only in state 3; IR changes in other states SHALL have no effect.
REQ-013 instr_done SHALL pulse 1 for exactly one cycle, registered alongside the transition into state 1, whenever the source state is not 0.
REQ-014 retired SHALL increment by 1 on each instr_done and wrap from 0xFFFF to 0x0000.
REQ-015 Watchdog counter (8 bit):
  - cleared on every entry into a wait state
  - incremented each wait cycle with mem_ready=0
  - when it equals WD_MAX and mem_ready=0, the next state SHALL be 22 and err SHALL be set
REQ-016 mem_ready=1 on the same cycle the count reaches WD_MAX SHALL win: the state advances normally and err is not set.
REQ-017 State 22 (HALT): halted=1 and the state holds regardless of run and mem_ready; only reset exits.
REQ-018 err SHALL remain 1 until reset.
REQ-019 Any StateID value not listed in REQ-005 to REQ-017 SHALL go to 22 on the next cycle.
REQ-020 run SHALL be ignored in every state except 0.

Reset
REQ-021 With reset=1 at a clock edge, the block SHALL set StateID=0, mem_req=0, instr_done=0, retired=0, err=0, halted=0 and watchdog counter=0.
REQ-022 Reset SHALL override every other input, including in a wait state, during a retire pulse, and in HALT.
REQ-023 After reset the block SHALL wait in state 0 for run=1.

Verification
REQ-024 ADD retire:
  - stimulus: reset, then run=1; IR=0x1000; mem_ready=1 throughout
  - response: StateID 0, 1, 2, 3, 4, 5, 1; instr_done=1 on the cycle StateID returns to 1; retired=1
REQ-025 Branch not taken and taken:
  - stimulus: IR=0x0800, N=0 -> 3 then 1, instr_done=1, state 6 skipped
  - stimulus: same with N=1 -> 3, 6, 1
REQ-026 Wait hold:
  - stimulus: LDW IR=0x6000 with mem_ready=0 for 10 cycles in state 24
  - response: StateID stays 24 and mem_req=1 for those 10 cycles, then 18 on the first mem_ready=1; err=0
REQ-027 Watchdog:
  - stimulus: mem_ready=0 held in state 2
  - response: after WD_MAX wait cycles StateID=22, err=1, halted=1, and state 22 holds under run=1/mem_ready=1
  - stimulus: same with mem_ready=1 on the limit cycle -> advance to 3 and err=0
REQ-028 Illegal opcode and reset:
  - stimulus: IR=0xF000 -> 3 then 22, halted=1
  - stimulus: reset=1 for one cycle -> all outputs at reset values, StateID=0
REQ-029 Counter wrap:
  - stimulus: force retired to 0xFFFF, retire one JMP (IR=0xC000)
  - response: retired=0x0000 and instr_done pulses once
